// File: rtl/dbus_lsu.sv
// Load/store unit: turns one MEM-stage access into a byte-lane data-bus request and formats the reply.
// Latency: bus request from the cycle after accept; response pulse one cycle after data_ok (or timeout); errors respond one cycle after accept.
// Backpressure: req_ready is high only in IDLE; stall_o holds the pipeline while busy or while an access is offered.
module dbus_lsu #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_info,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  dreq_valid,
    output logic [ADDR_W-1:0]     dreq_addr,
    output logic [2:0]            dreq_size,
    output logic [DATA_W/8-1:0]   dreq_strobe,
    output logic [DATA_W-1:0]     dreq_data,
    input  logic                  dresp_data_ok,
    input  logic [DATA_W-1:0]     dresp_data,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_data,
    output logic [1:0]            resp_err,
    output logic                  stall_o
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_MISALGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {IDLE, REQ_WAIT, RESP, ERR} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]          info_q, info_d;
    logic                we_q, we_d;
    logic [NB-1:0]       strobe_q, strobe_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [1:0]          req_size;
    logic [OFF_W-1:0]    req_off;
    logic                illegal;
    logic                misaligned;
    logic [NB-1:0]       base_mask;
    logic [DATA_W-1:0]   lane;
    logic [DATA_W-1:0]   load_fmt;
    logic                to_hit;

    assign req_size = req_info[1:0];
    assign req_off  = req_addr[OFF_W-1:0];

    // Decode legality, byte-lane mask and load-data formatting for the incoming and pending accesses
    always_comb begin
        illegal = (req_info == 3'd7) ||
                  ((DATA_W == 32) && ((req_info == 3'd3) || (req_info == 3'd6)));
        case (req_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            default: misaligned = |req_addr[2:0];
        endcase
        case (req_size)
            2'd0:    base_mask = NB'(1);
            2'd1:    base_mask = NB'(3);
            2'd2:    base_mask = NB'(15);
            default: base_mask = '1;
        endcase
        lane = dresp_data >> {addr_q[OFF_W-1:0], 3'b000};
        case (info_q)
            3'd0:    load_fmt = DATA_W'($signed(lane[7:0]));
            3'd1:    load_fmt = DATA_W'($signed(lane[15:0]));
            3'd2:    load_fmt = DATA_W'($signed(lane[31:0]));
            3'd3:    load_fmt = lane;
            3'd4:    load_fmt = DATA_W'(lane[7:0]);
            3'd5:    load_fmt = DATA_W'(lane[15:0]);
            3'd6:    load_fmt = DATA_W'(lane[31:0]);
            default: load_fmt = '0;
        endcase
        to_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);
    end

    // State and datapath registers; reset also abandons any outstanding bus request
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            info_q   <= '0;
            we_q     <= 1'b0;
            strobe_q <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= ERR_OK;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            info_q   <= info_d;
            we_q     <= we_d;
            strobe_q <= strobe_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next state: accept in IDLE, wait for data_ok or timeout, then a single response cycle
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        info_d   = info_q;
        we_d     = we_q;
        strobe_d = strobe_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    rdata_d = '0;
                    if (illegal || misaligned) begin
                        // Illegal size outranks misalignment; no bus request is made
                        state_d = ERR;
                        err_d   = illegal ? ERR_ILLEGAL : ERR_MISALGN;
                    end else begin
                        state_d  = REQ_WAIT;
                        err_d    = ERR_OK;
                        addr_d   = req_addr;
                        info_d   = req_info;
                        we_d     = req_we;
                        strobe_d = base_mask << req_off;
                        wdata_d  = req_wdata << {req_off, 3'b000};
                        cnt_d    = '0;
                    end
                end
            end
            REQ_WAIT: begin
                // data_ok on the expiry cycle still counts as a good completion
                if (dresp_data_ok) begin
                    state_d = RESP;
                    err_d   = ERR_OK;
                    rdata_d = we_q ? '0 : load_fmt;
                end else if (to_hit) begin
                    state_d = RESP;
                    err_d   = ERR_TIMEOUT;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from the current state and latched request
    always_comb begin
        req_ready   = (state_q == IDLE);
        dreq_valid  = (state_q == REQ_WAIT);
        resp_valid  = (state_q == RESP) || (state_q == ERR);
        dreq_addr   = addr_q;
        dreq_size   = {1'b0, info_q[1:0]};
        dreq_strobe = strobe_q;
        dreq_data   = wdata_q;
        resp_data   = resp_valid ? rdata_q : '0;
        resp_err    = resp_valid ? err_q : ERR_OK;
        stall_o     = (state_q != IDLE) || req_valid;
    end

endmodule

// File: tb/tb_dbus_lsu.sv
// Bench for dbus_lsu: a 64-bit instance and a 32-bit instance, both with a 4-cycle bus timeout.
// Stimulus pushes expected responses (cycle, data, error) into per-instance queues.
// Negedge monitors pop and compare whenever resp_valid is seen.
module tb_dbus_lsu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          cyc;
        logic [63:0] data;
        logic [1:0]  err;
    } exp_t;

    exp_t q64[$];
    exp_t q32[$];

    logic        rst = 1'b1;

    // 64-bit instance
    logic        req_valid = 0, req_we = 0, dresp_data_ok = 0;
    logic [2:0]  req_info = 0;
    logic [63:0] req_addr = 0, req_wdata = 0, dresp_data = 0;
    logic        req_ready, dreq_valid, resp_valid, stall_o;
    logic [63:0] dreq_addr, dreq_data, resp_data;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [1:0]  resp_err;

    // 32-bit instance
    logic        b_req_valid = 0, b_req_we = 0, b_dresp_data_ok = 0;
    logic [2:0]  b_req_info = 0;
    logic [31:0] b_req_addr = 0, b_req_wdata = 0, b_dresp_data = 0;
    logic        b_req_ready, b_dreq_valid, b_resp_valid, b_stall_o;
    logic [31:0] b_dreq_addr, b_dreq_data, b_resp_data;
    logic [2:0]  b_dreq_size;
    logic [3:0]  b_dreq_strobe;
    logic [1:0]  b_resp_err;

    dbus_lsu #(.DATA_W(64), .ADDR_W(64), .TIMEOUT(4)) u_dut64 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_info(req_info), .req_addr(req_addr), .req_wdata(req_wdata),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .stall_o(stall_o)
    );

    dbus_lsu #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) u_dut32 (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_info(b_req_info), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .dreq_valid(b_dreq_valid), .dreq_addr(b_dreq_addr), .dreq_size(b_dreq_size),
        .dreq_strobe(b_dreq_strobe), .dreq_data(b_dreq_data),
        .dresp_data_ok(b_dresp_data_ok), .dresp_data(b_dresp_data),
        .resp_valid(b_resp_valid), .resp_data(b_resp_data), .resp_err(b_resp_err),
        .stall_o(b_stall_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor, 64-bit instance
    always @(negedge clk) begin : mon64
        exp_t e;
        if (resp_valid === 1'b1) begin
            if (q64.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp64_unexpected: got resp_valid=1 data=0x%0h err=%0d, expected none (cycle %0d)",
                         resp_data, resp_err, cyc);
            end else begin
                e = q64.pop_front();
                check("resp64_cycle", 64'(cyc), 64'(e.cyc));
                check("resp64_data", resp_data, e.data);
                check("resp64_err", 64'(resp_err), 64'(e.err));
            end
        end
    end

    // Scoreboard monitor, 32-bit instance
    always @(negedge clk) begin : mon32
        exp_t e;
        if (b_resp_valid === 1'b1) begin
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp32_unexpected: got resp_valid=1 data=0x%0h err=%0d, expected none (cycle %0d)",
                         b_resp_data, b_resp_err, cyc);
            end else begin
                e = q32.pop_front();
                check("resp32_cycle", 64'(cyc), 64'(e.cyc));
                check("resp32_data", 64'(b_resp_data), e.data);
                check("resp32_err", 64'(b_resp_err), 64'(e.err));
            end
        end
    end

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one access; returns the cycle count just after the accepting edge
    task automatic issue64(input logic we, input logic [2:0] info, input logic [63:0] addr,
                           input logic [63:0] wdata, output int acc);
        req_valid = 1'b1; req_we = we; req_info = info; req_addr = addr; req_wdata = wdata;
        #1;
        check("ready64_on_issue", 64'(req_ready), 64'd1);
        check("stall64_on_issue", 64'(stall_o), 64'd1);
        @(posedge clk); #1;
        acc = cyc;
        req_valid = 1'b0;
    endtask

    task automatic respond64(input logic [63:0] data);
        dresp_data_ok = 1'b1; dresp_data = data;
        @(posedge clk); #1;
        dresp_data_ok = 1'b0; dresp_data = '0;
    endtask

    task automatic issue32(input logic we, input logic [2:0] info, input logic [31:0] addr,
                           input logic [31:0] wdata, output int acc);
        b_req_valid = 1'b1; b_req_we = we; b_req_info = info; b_req_addr = addr; b_req_wdata = wdata;
        #1;
        check("ready32_on_issue", 64'(b_req_ready), 64'd1);
        @(posedge clk); #1;
        acc = cyc;
        b_req_valid = 1'b0;
    endtask

    task automatic respond32(input logic [31:0] data);
        b_dresp_data_ok = 1'b1; b_dresp_data = data;
        @(posedge clk); #1;
        b_dresp_data_ok = 1'b0; b_dresp_data = '0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int acc;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;

        // Reset state
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_dreq_valid", 64'(dreq_valid), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_dreq_strobe", 64'(dreq_strobe), 64'd0);
        check("rst_dreq_addr", dreq_addr, 64'd0);
        check("rst_stall", 64'(stall_o), 64'd0);
        @(posedge clk); #1;

        // lb 0x1003: sign-extended byte from lane 3, response one cycle after data_ok
        issue64(1'b0, 3'd0, 64'h1003, 64'd0, acc);
        check("lb_dreq_valid", 64'(dreq_valid), 64'd1);
        check("lb_dreq_addr", dreq_addr, 64'h1003);
        check("lb_dreq_size", 64'(dreq_size), 64'd0);
        check("lb_dreq_strobe", 64'(dreq_strobe), 64'h08);
        q64.push_back('{cyc + 1, 64'hFFFF_FFFF_FFFF_FF80, 2'b00});
        respond64(64'h0000_0000_8000_0000);
        check("lb_dreq_drop", 64'(dreq_valid), 64'd0);
        gap(1);

        // lwu 0x2004 with two wait cycles: request held stable
        issue64(1'b0, 3'd6, 64'h2004, 64'd0, acc);
        gap(1);
        check("lwu_hold_valid", 64'(dreq_valid), 64'd1);
        check("lwu_hold_addr", dreq_addr, 64'h2004);
        gap(1);
        check("lwu_hold_size", 64'(dreq_size), 64'd2);
        check("lwu_stall_wait", 64'(stall_o), 64'd1);
        q64.push_back('{cyc + 1, 64'h0000_0000_DEAD_BEEF, 2'b00});
        respond64(64'hDEAD_BEEF_0000_0000);
        gap(1);

        // sh 0x3006: strobe and data on the top two lanes, store returns 0
        issue64(1'b1, 3'd1, 64'h3006, 64'h0000_0000_0000_ABCD, acc);
        check("sh_dreq_strobe", 64'(dreq_strobe), 64'hC0);
        check("sh_dreq_data", dreq_data, 64'hABCD_0000_0000_0000);
        check("sh_dreq_size", 64'(dreq_size), 64'd1);
        q64.push_back('{cyc + 1, 64'd0, 2'b00});
        respond64(64'hFFFF_FFFF_FFFF_FFFF);
        gap(1);

        // lw 0x4002: misaligned, response on the cycle after accept, no bus request
        issue64(1'b0, 3'd2, 64'h4002, 64'd0, acc);
        q64.push_back('{acc, 64'd0, 2'b01});
        check("misal_no_dreq", 64'(dreq_valid), 64'd0);
        gap(1);
        check("misal_no_dreq_after", 64'(dreq_valid), 64'd0);

        // info=7 on a misaligned address: illegal size outranks misalignment
        issue64(1'b0, 3'd7, 64'h5001, 64'd0, acc);
        q64.push_back('{acc, 64'd0, 2'b11});
        check("illegal_no_dreq", 64'(dreq_valid), 64'd0);
        gap(1);

        // Timeout: dreq_valid for 4 cycles, then err 10; late data_ok ignored
        issue64(1'b0, 3'd2, 64'h6000, 64'd0, acc);
        q64.push_back('{acc + 4, 64'd0, 2'b10});
        for (int i = 0; i < 4; i++) begin
            check($sformatf("to_dreq_valid_%0d", i), 64'(dreq_valid), 64'd1);
            gap(1);
        end
        check("to_dreq_dropped", 64'(dreq_valid), 64'd0);
        dresp_data_ok = 1'b1; dresp_data = 64'h1234;
        gap(2);
        dresp_data_ok = 1'b0; dresp_data = '0;
        gap(1);

        // data_ok on the expiry cycle wins over the timeout
        issue64(1'b0, 3'd2, 64'h7000, 64'd0, acc);
        gap(3);
        q64.push_back('{cyc + 1, 64'hFFFF_FFFF_8765_4321, 2'b00});
        respond64(64'h1234_5678_8765_4321);
        gap(1);

        // ld 0x8008: full doubleword
        issue64(1'b0, 3'd3, 64'h8008, 64'd0, acc);
        check("ld_dreq_strobe", 64'(dreq_strobe), 64'hFF);
        q64.push_back('{cyc + 1, 64'h0123_4567_89AB_CDEF, 2'b00});
        respond64(64'h0123_4567_89AB_CDEF);
        gap(1);

        // lhu and lh from lane 2
        issue64(1'b0, 3'd5, 64'h9002, 64'd0, acc);
        check("lhu_dreq_strobe", 64'(dreq_strobe), 64'h0C);
        q64.push_back('{cyc + 1, 64'h0000_0000_0000_8001, 2'b00});
        respond64(64'h0000_0000_8001_0000);
        gap(1);
        issue64(1'b0, 3'd1, 64'h9002, 64'd0, acc);
        q64.push_back('{cyc + 1, 64'hFFFF_FFFF_FFFF_8001, 2'b00});
        respond64(64'h0000_0000_8001_0000);
        gap(1);

        // Reset during REQ_WAIT: all outputs cleared, later bus response discarded
        issue64(1'b1, 3'd0, 64'hA005, 64'h77, acc);
        rst = 1'b1;
        gap(1);
        rst = 1'b0;
        #1;
        check("midrst_ready", 64'(req_ready), 64'd1);
        check("midrst_dreq_valid", 64'(dreq_valid), 64'd0);
        check("midrst_resp_valid", 64'(resp_valid), 64'd0);
        check("midrst_strobe", 64'(dreq_strobe), 64'd0);
        check("midrst_addr", dreq_addr, 64'd0);
        check("midrst_data", dreq_data, 64'd0);
        check("midrst_resp_data", resp_data, 64'd0);
        check("midrst_resp_err", 64'(resp_err), 64'd0);
        @(posedge clk); #1;
        dresp_data_ok = 1'b1; dresp_data = 64'hFFFF;
        gap(1);
        dresp_data_ok = 1'b0; dresp_data = '0;
        gap(2);

        // 32-bit instance: ld and lwu are illegal sizes
        issue32(1'b0, 3'd3, 32'h100, 32'd0, acc);
        q32.push_back('{acc, 64'd0, 2'b11});
        check("w32_ld_no_dreq", 64'(b_dreq_valid), 64'd0);
        gap(1);
        issue32(1'b0, 3'd6, 32'h104, 32'd0, acc);
        q32.push_back('{acc, 64'd0, 2'b11});
        gap(1);

        // 32-bit lw, lb, sb
        issue32(1'b0, 3'd2, 32'h104, 32'd0, acc);
        check("w32_lw_strobe", 64'(b_dreq_strobe), 64'hF);
        q32.push_back('{cyc + 1, 64'h0000_0000_CAFE_F00D, 2'b00});
        respond32(32'hCAFE_F00D);
        gap(1);
        issue32(1'b0, 3'd0, 32'h103, 32'd0, acc);
        check("w32_lb_strobe", 64'(b_dreq_strobe), 64'h8);
        q32.push_back('{cyc + 1, 64'h0000_0000_FFFF_FF80, 2'b00});
        respond32(32'h8000_0000);
        gap(1);
        issue32(1'b1, 3'd0, 32'h102, 32'h5A, acc);
        check("w32_sb_strobe", 64'(b_dreq_strobe), 64'h4);
        check("w32_sb_data", 64'(b_dreq_data), 64'h005A_0000);
        q32.push_back('{cyc + 1, 64'd0, 2'b00});
        respond32(32'h1111_1111);
        gap(3);

        check("sb64_drained", 64'(q64.size()), 64'd0);
        check("sb32_drained", 64'(q32.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
